// File: rtl/adc_chan_avg.sv
// adc_chan_avg: per-channel boxcar averager for captured ADC readings.
// Each channel sums 2^LOG2_AVG samples and emits the mean through a 2-entry
// ready/valid FIFO. A result arriving while the FIFO is full and not draining
// is dropped and latches the sticky overflow flag.
// Optional: define ADC_AVG_MINMAX_EN to add per-window m_min/m_max outputs.
module adc_chan_avg #(
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned CH_W     = 1,
    parameter int unsigned LOG2_AVG = 4
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              s_valid,
    input  logic [CH_W-1:0]   s_chan,
    input  logic [DATA_W-1:0] s_data,
    input  logic              clr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_chan,
    output logic [DATA_W-1:0] m_data,
    output logic              overflow
`ifdef ADC_AVG_MINMAX_EN
    ,
    output logic [DATA_W-1:0] m_min,
    output logic [DATA_W-1:0] m_max
`endif
);

    localparam int unsigned NCH      = 1 << CH_W;
    localparam int unsigned ACC_W    = DATA_W + LOG2_AVG;
    localparam int unsigned CNT_W    = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int unsigned WIN      = 1 << LOG2_AVG;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

    logic [ACC_W-1:0]  r_acc [NCH];
    logic [CNT_W-1:0]  r_cnt [NCH];

    logic [DATA_W-1:0] r_fifo_data [2];
    logic [CH_W-1:0]   r_fifo_chan [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic              r_overflow;

    logic              w_accept;
    logic              w_last;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_result;

`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0] r_min [NCH];
    logic [DATA_W-1:0] r_max [NCH];
    logic [DATA_W-1:0] r_fifo_min [2];
    logic [DATA_W-1:0] r_fifo_max [2];
    logic [DATA_W-1:0] w_win_min;
    logic [DATA_W-1:0] w_win_max;
`endif

    // Sample acceptance, window-complete detection and FIFO push/pop decisions
    always_comb begin
        w_accept = s_valid & ~clr;
        w_last   = (r_cnt[s_chan] == CNT_LAST);
        w_sum    = r_acc[s_chan] + ACC_W'(s_data);
        w_result = DATA_W'(w_sum >> LOG2_AVG);
        w_push   = w_accept & w_last;
        w_pop    = (r_count != 2'd0) & m_ready;
        // a full FIFO still takes the new result if its head leaves this cycle
        w_wr_en  = w_push & ((r_count != 2'd2) | w_pop);
        w_drop   = w_push & ~w_wr_en;
    end

    // Per-channel running sums and sample counters
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (s_valid) begin
            if (w_last) begin
                r_acc[s_chan] <= '0;
                r_cnt[s_chan] <= '0;
            end else begin
                r_acc[s_chan] <= w_sum;
                r_cnt[s_chan] <= r_cnt[s_chan] + CNT_W'(1);
            end
        end
    end

`ifdef ADC_AVG_MINMAX_EN
    // Window extremes including the sample currently being accepted
    always_comb begin
        w_win_min = (s_data < r_min[s_chan]) ? s_data : r_min[s_chan];
        w_win_max = (s_data > r_max[s_chan]) ? s_data : r_max[s_chan];
    end

    // Per-channel min/max trackers, re-armed at every window start
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_min[i] <= '1;
                r_max[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_min[i] <= '1;
                r_max[i] <= '0;
            end
        end else if (s_valid) begin
            if (w_last) begin
                r_min[s_chan] <= '1;
                r_max[s_chan] <= '0;
            end else begin
                r_min[s_chan] <= w_win_min;
                r_max[s_chan] <= w_win_max;
            end
        end
    end
`endif

    // Two-entry result FIFO with separate read/write pointers
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_chan[i] <= '0;
`ifdef ADC_AVG_MINMAX_EN
                r_fifo_min[i]  <= '0;
                r_fifo_max[i]  <= '0;
`endif
            end
        end else begin
            if (w_wr_en) begin
                r_fifo_data[r_wr_ptr] <= w_result;
                r_fifo_chan[r_wr_ptr] <= s_chan;
`ifdef ADC_AVG_MINMAX_EN
                r_fifo_min[r_wr_ptr]  <= w_win_min;
                r_fifo_max[r_wr_ptr]  <= w_win_max;
`endif
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for any completed result lost to a full FIFO
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Head of FIFO drives the result interface
    always_comb begin
        m_valid  = (r_count != 2'd0);
        m_chan   = r_fifo_chan[r_rd_ptr];
        m_data   = r_fifo_data[r_rd_ptr];
        overflow = r_overflow;
`ifdef ADC_AVG_MINMAX_EN
        m_min    = r_fifo_min[r_rd_ptr];
        m_max    = r_fifo_max[r_rd_ptr];
`endif
    end

endmodule

// File: tb/tb_adc_chan_avg.sv
// Testbench for adc_chan_avg (LOG2_AVG=2, two channels): vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_adc_chan_avg;

    localparam int unsigned DATA_W   = 14;
    localparam int unsigned CH_W     = 1;
    localparam int unsigned LOG2_AVG = 2;
    localparam int unsigned WIN      = 4;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              s_valid = 1'b0;
    logic [CH_W-1:0]   s_chan = '0;
    logic [DATA_W-1:0] s_data = '0;
    logic              clr = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [CH_W-1:0]   m_chan;
    logic [DATA_W-1:0] m_data;
    logic              overflow;
`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0] m_min;
    logic [DATA_W-1:0] m_max;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    adc_chan_avg #(
        .DATA_W  (DATA_W),
        .CH_W    (CH_W),
        .LOG2_AVG(LOG2_AVG)
    ) dut (
        .clk     (clk),
        .rst_i   (rst_i),
        .s_valid (s_valid),
        .s_chan  (s_chan),
        .s_data  (s_data),
        .clr     (clr),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_chan  (m_chan),
        .m_data  (m_data),
        .overflow(overflow)
`ifdef ADC_AVG_MINMAX_EN
        ,
        .m_min   (m_min),
        .m_max   (m_max)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        int unsigned ch;
        int unsigned d;
        logic        c;
        logic        ev;
        int unsigned ech;
        int unsigned ed;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        int unsigned ch;
        int unsigned mean;
        int unsigned mn;
        int unsigned mx;
    } res_t;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input int unsigned ch, input int unsigned d, input logic c,
                       input logic ev, input int unsigned ech, input int unsigned ed);
        vec_t r;
        r.v = v; r.ch = ch; r.d = d; r.c = c; r.ev = ev; r.ech = ech; r.ed = ed;
        tbl.push_back(r);
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the clock edge
    task automatic step(input logic v, input int unsigned ch, input int unsigned d,
                        input logic c, input logic rdy);
        s_valid = v;
        s_chan  = CH_W'(ch);
        s_data  = DATA_W'(d);
        clr     = c;
        m_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        rst_i = 1'b1;
        s_valid = 1'b0;
        clr = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    int unsigned win_q[2][$];
    res_t        fifo_q[$];
    bit          ovf_m;

    initial begin
        // ---------------- reset state ----------------
        #2 rst_i = 1'b1;
        #2;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_chan", 32'(m_chan), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // ---------------- table-driven vectors (m_ready=1) ----------------
        add(1, 0, 100, 0, 0, 0, 0);
        add(1, 0, 101, 0, 0, 0, 0);
        add(1, 0, 102, 0, 0, 0, 0);
        add(1, 0, 105, 0, 1, 0, 102);
        add(0, 0, 0,   0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            add(1, 0, 1000,  0, k == 3, 0, 1000);
            add(1, 1, 16383, 0, k == 3, 1, 16383);
        end
        add(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 50, 0, 0, 0, 0);
        add(1, 0, 999, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 10, 0, 0, 0, 0);
        add(1, 0, 10, 0, 1, 0, 10);
        add(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].c, 1'b1);
            chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_chan", i), 32'(m_chan), tbl[i].ech);
                chk($sformatf("tbl%0d_data", i), 32'(m_data), tbl[i].ed);
            end
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 0);
        end

        // ---------------- FIFO full: hold, drop, overflow ----------------
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) step(1, 0, 200 + 100 * w, 0, 1'b0);
            chk($sformatf("hold%0d_valid", w), 32'(m_valid), 1);
            chk($sformatf("hold%0d_data", w), 32'(m_data), 200);
            chk($sformatf("hold%0d_ovf", w), 32'(overflow), (w == 2) ? 1 : 0);
        end
        step(0, 0, 0, 0, 1'b0);
        chk("hold_idle_data", 32'(m_data), 200);
        step(0, 0, 0, 0, 1'b1);
        chk("drain1_valid", 32'(m_valid), 1);
        chk("drain1_data", 32'(m_data), 300);
        step(0, 0, 0, 0, 1'b1);
        chk("drain2_valid", 32'(m_valid), 0);
        chk("drain2_ovf", 32'(overflow), 1);

        // ---------------- asynchronous reset mid-window ----------------
        for (int k = 0; k < 4; k++) step(1, 1, 7000, 0, 1'b0);
        step(1, 0, 5000, 0, 1'b0);
        step(1, 0, 5000, 0, 1'b0);
        chk("prerst_valid", 32'(m_valid), 1);
        s_valid = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", 32'(m_valid), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_data", 32'(m_data), 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        for (int k = 0; k < 4; k++) step(1, 0, 20, 0, 1'b1);
        chk("postrst_valid", 32'(m_valid), 1);
        chk("postrst_chan", 32'(m_chan), 0);
        chk("postrst_data", 32'(m_data), 20);

        // ---------------- window min/max (mean checked in every build) -------
        step(1, 1, 7, 0, 1'b1);
        step(1, 1, 3, 0, 1'b1);
        step(1, 1, 9, 0, 1'b1);
        step(1, 1, 5, 0, 1'b1);
        chk("mm_valid", 32'(m_valid), 1);
        chk("mm_chan", 32'(m_chan), 1);
        chk("mm_data", 32'(m_data), 6);
`ifdef ADC_AVG_MINMAX_EN
        chk("mm_min", 32'(m_min), 3);
        chk("mm_max", 32'(m_max), 9);
`endif
        step(0, 0, 0, 0, 1'b1);
        chk("mm_drained", 32'(m_valid), 0);

        // ---------------- randomized run vs reference model ----------------
        sync_reset();
        win_q[0].delete();
        win_q[1].delete();
        fifo_q.delete();
        ovf_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        v, c, rdy, popping, has_push;
            int unsigned ch, d, pct, sum, mn, mx;
            res_t        r;
            pct = ((cyc / 200) % 2 == 0) ? 90 : 15;
            v   = ($urandom % 10) < 7;
            c   = ($urandom % 50) == 0;
            rdy = ($urandom % 100) < pct;
            ch  = $urandom % 2;
            case ($urandom % 8)
                0:       d = 0;
                1:       d = 16383;
                default: d = $urandom % 16384;
            endcase
            popping  = (fifo_q.size() > 0) && rdy;
            has_push = 0;
            r = '{default: 0};
            if (c) begin
                win_q[0].delete();
                win_q[1].delete();
            end else if (v) begin
                win_q[ch].push_back(d);
                if (win_q[ch].size() == WIN) begin
                    sum = 0; mn = 16383; mx = 0;
                    foreach (win_q[ch][j]) begin
                        sum += win_q[ch][j];
                        if (win_q[ch][j] < mn) mn = win_q[ch][j];
                        if (win_q[ch][j] > mx) mx = win_q[ch][j];
                    end
                    r.ch = ch; r.mean = sum / WIN; r.mn = mn; r.mx = mx;
                    win_q[ch].delete();
                    has_push = 1;
                end
            end
            if (popping) void'(fifo_q.pop_front());
            if (has_push) begin
                if (fifo_q.size() < 2) fifo_q.push_back(r);
                else ovf_m = 1;
            end
            step(v, ch, d, c, rdy);
            chk($sformatf("rnd%0d_valid", cyc), 32'(m_valid), (fifo_q.size() > 0) ? 1 : 0);
            chk($sformatf("rnd%0d_ovf", cyc), 32'(overflow), 32'(ovf_m));
            if (fifo_q.size() > 0) begin
                chk($sformatf("rnd%0d_chan", cyc), 32'(m_chan), fifo_q[0].ch);
                chk($sformatf("rnd%0d_data", cyc), 32'(m_data), fifo_q[0].mean);
`ifdef ADC_AVG_MINMAX_EN
                chk($sformatf("rnd%0d_min", cyc), 32'(m_min), fifo_q[0].mn);
                chk($sformatf("rnd%0d_max", cyc), 32'(m_max), fifo_q[0].mx);
`endif
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
